// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the multi-cycle adder handshake controller.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2,
    VALID = 2'd3
  } ctrl_state_t;

  localparam int LAT_W = 8;

endpackage

// File: rtl/adder_hs_ctrl_lat_counter.sv
// Loadable down-counter that tracks the remaining compute cycles; holds at zero.
module lat_counter
  import adder_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adder_hs_ctrl.sv
// Ready/valid sequencer for the multi-cycle adder: operand/result load enables,
// parametrised compute latency, optional accept-on-drain overlap, transaction count.
module adder_hs_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int          LATENCY = 3,
  parameter int unsigned OVERLAP = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val_in,
  output logic             rdy_in,
  input  logic             rdy_out,
  output logic             val_out,
  output logic             ld_opnd,
  output logic             ld_res,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
    $error("adder_hs_ctrl: LATENCY=%0d outside legal range 1..255", LATENCY);
  end

  localparam logic             OVL      = (OVERLAP != 0);
  localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

  ctrl_state_t      state;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_zero;

  lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_opnd),
    .dec      (busy && !lat_zero),
    .load_val (LOAD_VAL),
    .cnt      (lat_cnt),
    .zero     (lat_zero)
  );

  // rdy_in depends only on state and rdy_out, so there is no path from val_in back to rdy_in.
  always_comb begin
    rdy_in  = 1'b0;
    val_out = 1'b0;
    busy    = 1'b0;
    ld_res  = 1'b0;
    case (state)
      READY: rdy_in = 1'b1;
      BUSY: begin
        busy   = 1'b1;
        ld_res = (lat_cnt == '0);
      end
      VALID: begin
        val_out = 1'b1;
        rdy_in  = OVL && rdy_out;
      end
      default: ;
    endcase
    ld_opnd = val_in && rdy_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      txn_cnt <= '0;
    end else begin
      case (state)
        IDLE:  state <= READY;
        READY: if (ld_opnd) state <= BUSY;
        BUSY:  if (lat_zero) state <= VALID;
        VALID: begin
          if (rdy_out) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
            state   <= ld_opnd ? BUSY : READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_hs_ctrl.sv
// Bench for adder_hs_ctrl: three configurations share stimulus and are compared
// each cycle against a transaction-timing reference model.
module tb_adder_hs_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, val_in, rdy_out;
  logic rdy_in_w[3], val_out_w[3], ld_opnd_w[3], ld_res_w[3], busy_w[3];
  logic [15:0] txn0, txn1;
  logic [3:0]  txn2;

  int compared = 0;
  int failed   = 0;

  // u0: LATENCY=3 no overlap; u1: LATENCY=3 overlap; u2: LATENCY=1, 4-bit counter
  adder_hs_ctrl #(.LATENCY(3), .OVERLAP(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .val_in(val_in), .rdy_in(rdy_in_w[0]), .rdy_out(rdy_out),
    .val_out(val_out_w[0]), .ld_opnd(ld_opnd_w[0]), .ld_res(ld_res_w[0]),
    .busy(busy_w[0]), .txn_cnt(txn0));
  adder_hs_ctrl #(.LATENCY(3), .OVERLAP(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .val_in(val_in), .rdy_in(rdy_in_w[1]), .rdy_out(rdy_out),
    .val_out(val_out_w[1]), .ld_opnd(ld_opnd_w[1]), .ld_res(ld_res_w[1]),
    .busy(busy_w[1]), .txn_cnt(txn1));
  adder_hs_ctrl #(.LATENCY(1), .OVERLAP(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .val_in(val_in), .rdy_in(rdy_in_w[2]), .rdy_out(rdy_out),
    .val_out(val_out_w[2]), .ld_opnd(ld_opnd_w[2]), .ld_res(ld_res_w[2]),
    .busy(busy_w[2]), .txn_cnt(txn2));

  // Model: busy cycles left of the current computation, result-held flag,
  // "just out of reset" flag and an unbounded handshake count.
  int m_left[3];
  bit m_hold[3];
  bit m_idle[3];
  int m_count[3];

  function automatic int lat_of(int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic bit ovl_of(int i);
    return (i == 1);
  endfunction

  function automatic logic [4:0] exp_vec(int i);
    bit can_take, take;
    can_take = !m_idle[i] && !m_hold[i] && (m_left[i] == 0);
    take     = can_take || (ovl_of(i) && m_hold[i] && rdy_out);
    return {take, m_hold[i], take && val_in, m_left[i] == 1, m_left[i] > 0};
  endfunction

  function automatic logic [4:0] act_vec(int i);
    return {rdy_in_w[i], val_out_w[i], ld_opnd_w[i], ld_res_w[i], busy_w[i]};
  endfunction

  function automatic logic [15:0] exp_txn(int i);
    return (i == 2) ? 16'(m_count[i] % 16) : 16'(m_count[i] % 65536);
  endfunction

  function automatic logic [15:0] act_txn(int i);
    case (i)
      0:       return txn0;
      1:       return txn1;
      default: return {12'd0, txn2};
    endcase
  endfunction

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_idle[i] = 1; m_left[i] = 0; m_hold[i] = 0; m_count[i] = 0;
      end else if (m_idle[i]) begin
        m_idle[i] = 0;
      end else if (m_hold[i]) begin
        if (rdy_out) begin
          m_count[i]++;
          m_hold[i] = 0;
          if (ovl_of(i) && val_in) m_left[i] = lat_of(i);
        end
      end else if (m_left[i] > 0) begin
        if (m_left[i] == 1) m_hold[i] = 1;
        m_left[i]--;
      end else if (val_in) begin
        m_left[i] = lat_of(i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      rst    = (c >= 2);
      val_in = (c >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rdy_out = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL reset.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
        compared++;
        if (act_txn(i) !== exp_txn(i)) begin
          failed++;
          $display("FAIL reset.txn u%0d c=%0d got %0d want %0d", i, c, act_txn(i), exp_txn(i));
        end
      end
      if (c == 2 || c == 3) begin
        compared++;
        if (rdy_in_w[0] !== (c == 3)) begin
          failed++;
          $display("FAIL reset.rdy_in_after_release c=%0d got %b want %b", c, rdy_in_w[0], c == 3);
        end
      end
      advance();
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 8; c++) begin
      val_in = (c == 0); rdy_out = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL single.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
      compared++;
      if ({ld_opnd_w[0], busy_w[0], ld_res_w[0], val_out_w[0]} !==
          {c == 0, c >= 1 && c <= 3, c == 3, c == 4}) begin
        failed++;
        $display("FAIL single.timing c=%0d got %b", c,
                 {ld_opnd_w[0], busy_w[0], ld_res_w[0], val_out_w[0]});
      end
      compared++;
      if (val_out_w[2] !== (c == 2)) begin
        failed++;
        $display("FAIL single.lat1_val_out c=%0d got %b want %b", c, val_out_w[2], c == 2);
      end
      if (c == 5) begin
        compared++;
        if (txn0 !== 16'd1) begin
          failed++;
          $display("FAIL single.txn c=5 got %0d want 1", txn0);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    for (int c = 0; c < 13; c++) begin
      val_in = (c == 0); rdy_out = (c >= 9);
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL bp.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
      if (ld_res_w[0]) pulses++;
      if (c >= 4 && c <= 9) begin
        compared++;
        if (val_out_w[0] !== 1'b1) begin
          failed++;
          $display("FAIL bp.val_out_held c=%0d got %b want 1", c, val_out_w[0]);
        end
      end
      if (c == 9 || c == 10) begin
        compared++;
        if (txn0 !== ((c == 9) ? 16'd1 : 16'd2)) begin
          failed++;
          $display("FAIL bp.txn c=%0d got %0d want %0d", c, txn0, (c == 9) ? 1 : 2);
        end
      end
      advance();
    end
    compared++;
    if (pulses != 1) begin
      failed++;
      $display("FAIL bp.ld_res_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      val_in  = 1'($urandom_range(0, 1));
      rdy_out = ($urandom_range(0, 9) < 7);
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL random.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
        compared++;
        if (act_txn(i) !== exp_txn(i)) begin
          failed++;
          $display("FAIL random.txn u%0d c=%0d got %0d want %0d", i, c, act_txn(i), exp_txn(i));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_busy();
    val_in = 1'b0; rdy_out = 1'b1;
    for (int c = 0; c < 12; c++) advance();
    for (int c = 0; c < 11; c++) begin
      val_in  = (c == 0);
      rdy_out = 1'b1;
      rst     = (c != 2);
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL midbusy.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
      if (c == 3) begin
        compared++;
        if ({act_vec(0), txn0} !== 21'd0) begin
          failed++;
          $display("FAIL midbusy.idle got outs=%b txn=%0d want 0", act_vec(0), txn0);
        end
      end
      if (c >= 3) begin
        compared++;
        if (val_out_w[0] !== 1'b0) begin
          failed++;
          $display("FAIL midbusy.val_out c=%0d got %b want 0", c, val_out_w[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_streaming();
    int hs0 = 0, hs1 = 0;
    rst = 1'b0; val_in = 1'b1; rdy_out = 1'b1;
    advance();
    rst = 1'b1;
    for (int c = 0; c < 56; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (act_vec(i) !== exp_vec(i)) begin
          failed++;
          $display("FAIL stream.outs u%0d c=%0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
      if (c >= 2 && c <= 51 && val_out_w[0] && rdy_out) hs0++;
      if (c >= 2 && c <= 41 && val_out_w[1] && rdy_out) hs1++;
      advance();
    end
    compared++;
    if (hs0 != 10) begin
      failed++;
      $display("FAIL stream.no_overlap_50cyc got %0d results want 10", hs0);
    end
    compared++;
    if (hs1 != 10) begin
      failed++;
      $display("FAIL stream.overlap_40cyc got %0d results want 10", hs1);
    end
  endtask

  task automatic test_wrap();
    bit s15 = 0, s16 = 0, s17 = 0;
    rst = 1'b0; val_in = 1'b1; rdy_out = 1'b1;
    advance();
    rst = 1'b1;
    for (int c = 0; c < 90 && !s17; c++) begin
      #1;
      compared++;
      if (act_txn(2) !== exp_txn(2)) begin
        failed++;
        $display("FAIL wrap.txn c=%0d got %0d want %0d", c, txn2, exp_txn(2));
      end
      if (m_count[2] == 15 && !s15) begin
        s15 = 1; compared++;
        if (txn2 !== 4'd15) begin failed++; $display("FAIL wrap.at15 got %0d want 15", txn2); end
      end
      if (m_count[2] == 16 && !s16) begin
        s16 = 1; compared++;
        if (txn2 !== 4'd0) begin failed++; $display("FAIL wrap.at16 got %0d want 0", txn2); end
      end
      if (m_count[2] == 17 && !s17) begin
        s17 = 1; compared++;
        if (txn2 !== 4'd1) begin failed++; $display("FAIL wrap.at17 got %0d want 1", txn2); end
      end
      advance();
    end
    if (!(s15 && s16 && s17)) begin
      compared++; failed++;
      $display("FAIL wrap.timeout got %0d handshakes want 17", m_count[2]);
    end
  endtask

  initial begin
    rst = 1'b0; val_in = 1'b0; rdy_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0; m_hold[i] = 0; m_idle[i] = 1; m_count[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_random();
    test_reset_mid_busy();
    test_streaming();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
